// File: rtl/aq_fadd_align_single.sv
`default_nettype none
// aq_fadd_align_single: two-stage single-precision FADD operand alignment (order, right-shift, sticky).
// Optional macro AQ_FADD_ALIGN_STICKY_EN folds shifted-out bits into out_small[0]; rev 1.0
module aq_fadd_align_single (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        flush,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [7:0]  exp_a,
  input  logic [7:0]  exp_b,
  input  logic [23:0] mant_a,
  input  logic [23:0] mant_b,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [7:0]  out_exp,
  output logic [27:0] out_big,
  output logic [27:0] out_small,
  output logic        out_swap,
  output logic [4:0]  out_shift
);

  logic        r_s1_vld;
  logic [27:0] r_s1_big;
  logic [27:0] r_s1_small;
  logic [7:0]  r_s1_exp;
  logic        r_s1_swap;
  logic [4:0]  r_s1_shift;

  logic        r_s2_vld;
  logic [27:0] r_s2_big;
  logic [27:0] r_s2_small;
  logic [7:0]  r_s2_exp;
  logic        r_s2_swap;
  logic [4:0]  r_s2_shift;

  logic        w_swap;
  logic [7:0]  w_exp_big;
  logic [7:0]  w_exp_small;
  logic [23:0] w_mant_big;
  logic [23:0] w_mant_small;
  logic [7:0]  w_diff;
  logic [4:0]  w_shift;
  logic        w_s2_adv;
  logic        w_accept;
  logic        w_s1_to_s2;
  logic [27:0] w_shifted;
  logic [27:0] w_small_aligned;

  // Ties on exponent are broken by mantissa so equal operands never swap.
  assign w_swap       = (exp_b > exp_a) | ((exp_b == exp_a) & (mant_b > mant_a));
  assign w_exp_big    = w_swap ? exp_b  : exp_a;
  assign w_exp_small  = w_swap ? exp_a  : exp_b;
  assign w_mant_big   = w_swap ? mant_b : mant_a;
  assign w_mant_small = w_swap ? mant_a : mant_b;
  assign w_diff       = w_exp_big - w_exp_small;
  assign w_shift      = (w_diff > 8'd31) ? 5'd31 : w_diff[4:0];

  assign w_s2_adv   = !r_s2_vld | out_rdy;
  assign in_rdy     = !r_s1_vld | w_s2_adv;
  assign w_accept   = in_vld & in_rdy;
  assign w_s1_to_s2 = r_s1_vld & w_s2_adv;

  assign w_shifted = r_s1_small >> r_s1_shift;

`ifdef AQ_FADD_ALIGN_STICKY_EN
  localparam logic [27:0] c_ALL_ONES = '1;
  logic w_lost;
  // Mask of the low r_s1_shift bits; a shift of 28 or more masks the whole word.
  assign w_lost          = |(r_s1_small & ~(c_ALL_ONES << r_s1_shift));
  assign w_small_aligned = {w_shifted[27:1], w_shifted[0] | w_lost};
`else
  assign w_small_aligned = w_shifted;
`endif

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      r_s1_vld   <= 1'b0;
      r_s1_big   <= 28'h0;
      r_s1_small <= 28'h0;
      r_s1_exp   <= 8'h0;
      r_s1_swap  <= 1'b0;
      r_s1_shift <= 5'h0;
      r_s2_vld   <= 1'b0;
      r_s2_big   <= 28'h0;
      r_s2_small <= 28'h0;
      r_s2_exp   <= 8'h0;
      r_s2_swap  <= 1'b0;
      r_s2_shift <= 5'h0;
    end else if (flush) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      if (in_rdy) begin
        r_s1_vld <= in_vld;
      end
      if (w_accept) begin
        r_s1_big   <= {1'b0, w_mant_big, 3'b000};
        r_s1_small <= {1'b0, w_mant_small, 3'b000};
        r_s1_exp   <= w_exp_big;
        r_s1_swap  <= w_swap;
        r_s1_shift <= w_shift;
      end
      if (w_s2_adv) begin
        r_s2_vld <= r_s1_vld;
      end
      if (w_s1_to_s2) begin
        r_s2_big   <= r_s1_big;
        r_s2_small <= w_small_aligned;
        r_s2_exp   <= r_s1_exp;
        r_s2_swap  <= r_s1_swap;
        r_s2_shift <= r_s1_shift;
      end
    end
  end

  assign out_vld   = r_s2_vld;
  assign out_exp   = r_s2_exp;
  assign out_big   = r_s2_big;
  assign out_small = r_s2_small;
  assign out_swap  = r_s2_swap;
  assign out_shift = r_s2_shift;

endmodule
`default_nettype wire

// File: tb/tb_aq_fadd_align_single.sv
`default_nettype none
// tb_aq_fadd_align_single: table vectors, directed pipeline sequences and random stream vs. arithmetic model.
module tb_aq_fadd_align_single;

  logic        clk = 1'b0;
  logic        cpurst_b, flush, in_vld, in_rdy, out_vld, out_rdy, out_swap;
  logic [7:0]  exp_a, exp_b, out_exp;
  logic [23:0] mant_a, mant_b;
  logic [27:0] out_big, out_small;
  logic [4:0]  out_shift;

  always #5 clk = ~clk;

  aq_fadd_align_single dut (
    .forever_cpuclk(clk), .cpurst_b(cpurst_b), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .exp_a(exp_a), .exp_b(exp_b), .mant_a(mant_a), .mant_b(mant_b),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_exp(out_exp), .out_big(out_big), .out_small(out_small),
    .out_swap(out_swap), .out_shift(out_shift)
  );

  typedef struct packed {
    logic [7:0]  e;
    logic [27:0] big;
    logic [27:0] sml;
    logic        swp;
    logic [4:0]  sh;
  } res_t;

  typedef struct {
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    res_t        x;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  res_t q[$];
  int   qacc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: order by magnitude as one number, align by dividing by 2^shift.
  function automatic res_t model(input logic [7:0] ea, input logic [7:0] eb,
                                 input logic [23:0] ma, input logic [23:0] mb);
    res_t   r;
    longint va, vb, sv, p;
    int     d;
    va    = longint'({ea, ma});
    vb    = longint'({eb, mb});
    r.swp = (vb > va);
    if (r.swp) begin
      r.e = eb; r.big = 28'(longint'(mb) * 8); sv = longint'(ma) * 8; d = int'(eb) - int'(ea);
    end else begin
      r.e = ea; r.big = 28'(longint'(ma) * 8); sv = longint'(mb) * 8; d = int'(ea) - int'(eb);
    end
    r.sh = (d > 31) ? 5'd31 : 5'(d);
    p = 1;
    repeat (int'(r.sh)) p = p * 2;
    r.sml = 28'(sv / p);
`ifdef AQ_FADD_ALIGN_STICKY_EN
    if ((sv % p) != 0) r.sml[0] = 1'b1;
`endif
    return r;
  endfunction

  // One clock: drive, check at negedge against the scoreboard, advance.
  task automatic step(input logic v, input logic fl, input logic ordy,
                      input logic [7:0] ea, input logic [7:0] eb,
                      input logic [23:0] ma, input logic [23:0] mb,
                      input logic use_tab, input res_t te, output logic acc);
    in_vld = v; flush = fl; out_rdy = ordy;
    exp_a = ea; exp_b = eb; mant_a = ma; mant_b = mb;
    @(negedge clk);
    chk("in_rdy", in_rdy, (q.size() < 2) || ordy);
    chk("out_vld", out_vld, (q.size() > 0) && (cyc >= qacc[0] + 2));
    if (out_vld && q.size() > 0) begin
      chk("out_exp", out_exp, q[0].e);
      chk("out_big", out_big, q[0].big);
      chk("out_small", out_small, q[0].sml);
      chk("out_swap", out_swap, q[0].swp);
      chk("out_shift", out_shift, q[0].sh);
      if (ordy) begin
        void'(q.pop_front());
        void'(qacc.pop_front());
      end
    end
    acc = v && in_rdy && !fl;
    if (acc) begin
      q.push_back(use_tab ? te : model(ea, eb, ma, mb));
      qacc.push_back(cyc);
    end
    if (fl) begin
      q.delete();
      qacc.delete();
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    logic a;
    step(1'b0, 1'b0, ordy, 8'h0, 8'h0, 24'h0, 24'h0, 1'b0, '0, a);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 10) begin
      idle(1'b1);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    q.delete();
    qacc.delete();
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_vld"}, out_vld, 1'b0);
    chk({nm, "_data"}, {out_exp, out_big, out_small, out_swap, out_shift}, '0);
  endtask

  vec_t tab[4];
  vec_t bp[3];

  initial begin
    logic a;
    int   k, n;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;

    tab[0] = '{8'd130, 8'd128, 24'h800000, 24'hC00000, '{8'd130, 28'h4000000, 28'h1800000, 1'b0, 5'd2}};
`ifdef AQ_FADD_ALIGN_STICKY_EN
    tab[1] = '{8'd130, 8'd160, 24'h800001, 24'h800000, '{8'd160, 28'h4000000, 28'h0000001, 1'b1, 5'd30}};
`else
    tab[1] = '{8'd130, 8'd160, 24'h800001, 24'h800000, '{8'd160, 28'h4000000, 28'h0000000, 1'b1, 5'd30}};
`endif
    tab[2] = '{8'd100, 8'd100, 24'h900000, 24'hA00000, '{8'd100, 28'h5000000, 28'h4800000, 1'b1, 5'd0}};
    tab[3] = '{8'd127, 8'd127, 24'hABCDEF, 24'hABCDEF, '{8'd127, 28'h55E6F78, 28'h55E6F78, 1'b0, 5'd0}};

    cpurst_b = 1'b0; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    exp_a = '0; exp_b = '0; mant_a = '0; mant_b = '0;
    repeat (3) @(posedge clk);
    #1;
    cpurst_b = 1'b1;
    @(negedge clk);
    chk_zero_outputs("reset");
    chk("reset_in_rdy", in_rdy, 1'b1);
    @(posedge clk); #1;
    cyc++;

    // Directed vectors, one at a time.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, tab[i].ea, tab[i].eb, tab[i].ma, tab[i].mb, 1'b1, tab[i].x, a);
      chk("tab_accept", a, 1'b1);
      drain();
    end

    // Backpressure: three offered back-to-back, downstream stalled for four cycles.
    for (int i = 0; i < 3; i++) begin
      bp[i].ea = 8'd120 + 8'(i); bp[i].eb = 8'd118;
      bp[i].ma = 24'h800000 | 24'(i * 24'h1357); bp[i].mb = 24'hF0000F;
      bp[i].x  = '0;
    end
    k = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 1'b0, 1'b0, bp[k].ea, bp[k].eb, bp[k].ma, bp[k].mb, 1'b0, '0, a);
      if (a) k++;
    end
    chk("bp_accepted", 64'(k), 64'd2);
    n = 0;
    while (k < 3 && n < 5) begin
      step(1'b1, 1'b0, 1'b1, bp[k].ea, bp[k].eb, bp[k].ma, bp[k].mb, 1'b0, '0, a);
      if (a) k++;
      n++;
    end
    chk("bp_third_accepted", 64'(k), 64'd3);
    drain();

    // Flush one cycle after accept, then flush with a same-cycle input.
    step(1'b1, 1'b0, 1'b1, 8'd90, 8'd80, 24'h812345, 24'hFFFFFF, 1'b0, '0, a);
    step(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 24'h0, 24'h0, 1'b0, '0, a);
    step(1'b1, 1'b1, 1'b1, 8'd70, 8'd60, 24'h812345, 24'hFFFFFF, 1'b0, '0, a);
    repeat (3) idle(1'b1);

    // Reset with both stages full.
    step(1'b1, 1'b0, 1'b0, 8'd50, 8'd40, 24'h8ABCDE, 24'hC00001, 1'b0, '0, a);
    step(1'b1, 1'b0, 1'b0, 8'd41, 8'd45, 24'h800000, 24'hFFFFFF, 1'b0, '0, a);
    idle(1'b0);
    cpurst_b = 1'b0;
    @(posedge clk); #1;
    cyc++;
    chk_zero_outputs("midreset");
    q.delete();
    qacc.delete();
    cpurst_b = 1'b1;
    @(negedge clk);
    chk("midreset_in_rdy", in_rdy, 1'b1);
    @(posedge clk); #1;
    cyc++;

    // Random stream with random backpressure.
    for (int i = 0; i < 400; i++) begin
      ea = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0:       eb = ea;
        1:       eb = ea + 8'($urandom_range(0, 40));
        2:       eb = ea - 8'($urandom_range(0, 40));
        default: eb = 8'($urandom_range(0, 255));
      endcase
      ma = {1'b1, 23'($urandom)};
      mb = ($urandom_range(0, 7) == 0) ? ma : {($urandom_range(0, 5) != 0), 23'($urandom)};
      step(($urandom_range(0, 3) != 0), 1'b0, ($urandom_range(0, 2) != 0),
           ea, eb, ma, mb, 1'b0, '0, a);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
